// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I load/store width codes, byte-mask and legality helpers.
// Optional feature macro used by the unit: LSU_MISALIGNED_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unshifted byte mask for the access width encoded in funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Stores only have signed-width codes; loads also have the unsigned ones.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !is_store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables, store
// data positioning, load merge across two words and sign/zero extension.
// With LSU_MISALIGNED_EN defined the second-word (ACC1) datapath exists.
module lsu_align
  import lsu_pkg::*;
(
`ifdef LSU_MISALIGNED_EN
  input  logic [31:0] i_hi_word,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wdata1,
`endif
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo_word,
  output logic        o_illegal,
  output logic        o_split,
  output logic [3:0]  o_be0,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask8;
  logic [4:0]  w_sh_lo;
  logic [31:0] w_merged;

  // Mask over two consecutive words; the upper nibble is the spill into word+4.
  assign w_mask8   = {4'b0000, size_mask(i_funct3)} << i_off;
  assign w_sh_lo   = {i_off, 3'b000};
  assign o_split   = |w_mask8[7:4];
  assign o_be0     = w_mask8[3:0];
  assign o_wdata0  = i_wdata << w_sh_lo;
  assign o_illegal = !funct3_legal(i_is_store, i_funct3);

`ifdef LSU_MISALIGNED_EN
  logic [5:0] w_sh_hi;

  // Only meaningful when split, so off is 1..3 and the shift is 8..24.
  assign w_sh_hi  = {3'd4 - {1'b0, i_off}, 3'b000};
  assign o_be1    = w_mask8[7:4];
  assign o_wdata1 = i_wdata >> w_sh_hi;
  assign w_merged = (i_lo_word >> w_sh_lo) | (o_split ? (i_hi_word << w_sh_hi) : 32'h0);
`else
  assign w_merged = i_lo_word >> w_sh_lo;
`endif

  // Mask the merged word to the access width and extend per funct3.
  // NOTE: assigning a default before the case keeps this purely combinational (no latch).
  always_comb begin
    o_rdata = w_merged;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_merged[7]}}, w_merged[7:0]};
      F3_H:    o_rdata = {{16{w_merged[15]}}, w_merged[15:0]};
      F3_BU:   o_rdata = {24'h0, w_merged[7:0]};
      F3_HU:   o_rdata = {16'h0, w_merged[15:0]};
      default: o_rdata = w_merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one request at a time, drives the data
// memory port with registered outputs and returns a one-cycle response.
// Define LSU_MISALIGNED_EN to perform word-crossing accesses as two memory
// cycles; otherwise such requests complete immediately with resp_err.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_addr,
  output logic [31:0] data_write,
  output logic [3:0]  data_write_byte,
  input  logic [31:0] data_read
);

  lsu_state_t  r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_write;
  logic [3:0]  r_data_write_byte;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_idle;
  logic        w_is_store;
  logic [2:0]  w_funct3;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [31:0] w_lo_word;
  logic        w_illegal;
  logic        w_split;
  logic [3:0]  w_be0;
  logic [31:0] w_wdata0;
  logic [31:0] w_rdata;
  logic        w_err;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_is_store = w_idle ? req_is_store : r_is_store;
  assign w_funct3   = w_idle ? req_funct3   : r_funct3;
  assign w_off      = w_idle ? req_addr[1:0] : r_off;

`ifdef LSU_MISALIGNED_EN
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [3:0]  w_be1;
  logic [31:0] w_wdata1;

  assign w_wdata   = w_idle ? req_wdata : r_wdata;
  assign w_lo_word = (r_state == ST_ACC1) ? r_word0 : data_read;
  assign w_err     = w_illegal;
`else
  assign w_wdata   = req_wdata;
  assign w_lo_word = data_read;
  assign w_err     = w_illegal | w_split;
`endif

  lsu_align u_align (
`ifdef LSU_MISALIGNED_EN
    .i_hi_word  (data_read),
    .o_be1      (w_be1),
    .o_wdata1   (w_wdata1),
`endif
    .i_is_store (w_is_store),
    .i_funct3   (w_funct3),
    .i_off      (w_off),
    .i_wdata    (w_wdata),
    .i_lo_word  (w_lo_word),
    .o_illegal  (w_illegal),
    .o_split    (w_split),
    .o_be0      (w_be0),
    .o_wdata0   (w_wdata0),
    .o_rdata    (w_rdata)
  );

  // Request FSM with registered memory-port and response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_is_store        <= 1'b0;
      r_funct3          <= 3'b000;
      r_off             <= 2'b00;
      r_data_addr       <= 32'h0;
      r_data_write      <= 32'h0;
      r_data_write_byte <= 4'b0000;
      r_resp_valid      <= 1'b0;
      r_resp_err        <= 1'b0;
      r_resp_rdata      <= 32'h0;
`ifdef LSU_MISALIGNED_EN
      r_wdata           <= 32'h0;
      r_word0           <= 32'h0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_off      <= req_addr[1:0];
`ifdef LSU_MISALIGNED_EN
            r_wdata    <= req_wdata;
`endif
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_state           <= ST_ACC0;
              r_data_addr       <= {req_addr[31:2], 2'b00};
              r_data_write_byte <= req_is_store ? w_be0 : 4'b0000;
              r_data_write      <= req_is_store ? w_wdata0 : 32'h0;
            end
          end
        end
        ST_ACC0: begin
`ifdef LSU_MISALIGNED_EN
          if (w_split) begin
            r_state           <= ST_ACC1;
            r_word0           <= data_read;
            r_data_addr       <= r_data_addr + 32'd4;
            r_data_write_byte <= r_is_store ? w_be1 : 4'b0000;
            r_data_write      <= r_is_store ? w_wdata1 : 32'h0;
          end else
`endif
          begin
            r_state           <= ST_RESP;
            r_data_addr       <= 32'h0;
            r_data_write      <= 32'h0;
            r_data_write_byte <= 4'b0000;
            r_resp_valid      <= 1'b1;
            r_resp_err        <= 1'b0;
            r_resp_rdata      <= r_is_store ? 32'h0 : w_rdata;
          end
        end
`ifdef LSU_MISALIGNED_EN
        ST_ACC1: begin
          r_state           <= ST_RESP;
          r_data_addr       <= 32'h0;
          r_data_write      <= 32'h0;
          r_data_write_byte <= 4'b0000;
          r_resp_valid      <= 1'b1;
          r_resp_err        <= 1'b0;
          r_resp_rdata      <= r_is_store ? 32'h0 : w_rdata;
        end
`endif
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = w_idle && !reset;
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;
  assign resp_rdata      = r_resp_rdata;
  assign data_addr       = r_data_addr;
  assign data_write      = r_data_write;
  assign data_write_byte = r_data_write_byte;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port in the pipelined RISC-V core's MEM stage. Accepts one load/store request at a time from the pipeline and drives the data memory's `data_addr` / `data_write` / `data_write_byte` / `data_read` interface. Generates word-aligned addresses and byte-lane enables, and aligns store data. Returns aligned, sign- or zero-extended load data through a valid-only response.

## Interface
Parameters: none. All widths are fixed at 32 bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse when the request completes.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`: illegal funct3 or unsupported misalignment.
- `data_addr`  out  32  word-aligned memory address (bits [1:0] = 0).
- `data_write`  out  32  lane-positioned store data.
- `data_write_byte`  out  4  byte write enables; 4'b0000 = read cycle.
- `data_read`  in  32  memory read word, combinational from `data_addr`.

## Operation
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code → error.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE → ACC0 on accept.
  - IDLE → RESP directly on an error request; memory is not touched.
  - ACC0 → ACC1 if the access is split, otherwise ACC0 → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
- `req_ready` = (state == IDLE) && !reset. The request is latched on accept; inputs are don't-care afterwards.
- Byte offset is `off = addr[1:0]`. Size is 1, 2 or 4 bytes. Enable mask for ACC0 = (size-mask << off)[3:0]; store data is shifted left by 8·off.
- Split condition: off + size > 4. ACC1 addresses word+4, uses enables (size-mask << off)[7:4], and shifts store data right by 8·(4−off).
- Load data:
  - Non-split: `data_read >> 8·off`.
  - Split: (ACC0 word >> 8·off) | (ACC1 word << 8·(4−off)).
  - The result is then masked to size and sign-extended for LB/LH, zero-extended for LBU/LHU.
- In ACC states, loads drive `data_write_byte` = 0000. Outside ACC states, `data_addr`, `data_write` and `data_write_byte` are all 0.
- Stores complete with `resp_rdata` = 0 and `resp_err` = 0.

## Timing
- Reset values: state IDLE; `data_addr`, `data_write`, `data_write_byte`, `resp_rdata` = 0; `resp_valid` = 0; `resp_err` = 0; `req_ready` = 0 while reset is high, 1 on the first cycle after it drops.
- Memory-side outputs are registered and change only on `clk` edges. `data_read` is sampled at the end of each ACC cycle.
- Latency, counting the accept edge as cycle 0:
  - Aligned: ACC0 in cycle 1, `resp_valid` in cycle 2.
  - Split: ACC0 in cycle 1, ACC1 in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid` in cycle 1.
- Throughput: no request is accepted while busy. A new request can be accepted in the cycle after RESP.
- Reset mid-operation: all outputs clear immediately and any in-flight request is dropped. If a split store is reset after ACC0, its first half stays written; this is defined behaviour.
- Address wrap: a split at 0xFFFFFFFF wraps ACC1 to address 0x00000000.

## Configuration
- `LSU_MISALIGNED_EN` defined: split accesses are performed as described above.
- `LSU_MISALIGNED_EN` undefined:
  - Any split-condition request is an error: `resp_err` = 1, response in cycle 1, no memory access.
  - The ACC1 state and second-word datapath are absent.
- Misaligned accesses that do not cross a word (e.g. LH at off 1) are legal in both configurations.

## Structure
- Shared package `lsu_pkg` holds:
  - The state enum `lsu_state_t`.
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The size-mask function.
- Sub-module `lsu_align`: purely combinational. Handles store lane shifting, enable generation, load merge and extension. It is instantiated once; the FSM and registers live in `load_store_unit`.

## Test plan
Memory preload for all scenarios: word 0x10 = 0x8899AABB, word 0x14 = 0x11223344.
- **SB** at 0x13, data 0x000000CD → cycle 1: `data_addr` 0x10, `data_write_byte` 1000, `data_write` 0xCD000000; `resp_valid` in cycle 2 with `resp_err` 0.
- **Byte and halfword loads:**
  - LB 0x13 → `resp_rdata` 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH 0x12 → 0xFFFF8899.
  - LHU 0x11 → 0x000099AA.
- **LW at 0x12 with `LSU_MISALIGNED_EN`** → ACC0 reads 0x10, ACC1 reads 0x14; `resp_rdata` 0x33448899 in cycle 3.
- **LW at 0x12 without `LSU_MISALIGNED_EN`** → `resp_valid` and `resp_err` in cycle 1; `data_write_byte` never leaves 0.
- **SW at 0x13, data 0xDEADBEEF, with `LSU_MISALIGNED_EN`** → ACC0: addr 0x10, enables 1000, data 0xEF000000. ACC1: addr 0x14, enables 0111, data 0x00DEADBE.
- **Error and reset:**
  - funct3 011 load → `resp_err` 1 in cycle 1.
  - Reset asserted during ACC0 of an SW → all outputs 0 immediately; `req_ready` 1 in the first cycle after deassert.
